// File: rtl/pdp8_pkg.sv
// Shared PDP-8 datapath constants and bus-slicing helpers.
package pdp8_pkg;

    // Native machine word width.
    localparam int unsigned WORD_W = 12;

    // Index of the lowest bit of bus k in a flat, concatenated bus vector.
    function automatic int unsigned bus_lsb(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Strobe rising-edge detector: registers the strobe and flags a low-to-high change.
// A strobe that stays high is reported once. It re-arms only after a low sample.
module rise_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic strobe_i,
    output logic rise_o
);

    logic strobe_q;
    logic strobe_d;

    // The next state is the current strobe sample.
    always_comb begin
        strobe_d = strobe_i;
    end

    // Previous-sample register. Reset clears it, so a strobe already high at release fires.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= strobe_d;
        end
    end

    // The rise is combinational so the owning register can act on the same edge.
    always_comb begin
        rise_o = strobe_i & ~strobe_q;
    end

endmodule

// File: rtl/multilatch_n.sv
// Clear/hold/latch datapath register with increment and NOUT output buses.
// Build option MULTILATCH_TRISTATE_EN: when defined, disabled buses float (z).
// When it is undefined, disabled buses drive 0 so they can be OR-combined.
module multilatch_n
    import pdp8_pkg::*;
#(
    parameter int unsigned       WIDTH     = WORD_W,
    parameter int unsigned       NOUT      = 2,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [WIDTH-1:0]      in,
    input  logic                  clear,
    input  logic                  hold,
    input  logic                  latch,
    input  logic                  inc,
    input  logic [NOUT-1:0]       oe,
    output logic [NOUT*WIDTH-1:0] out,
    output logic [WIDTH-1:0]      data_o,
    output logic                  loaded,
    output logic                  carry
);

    logic [WIDTH-1:0] hold_q, hold_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             carry_q, carry_d;
    logic             loaded_q, loaded_d;
    logic [WIDTH-1:0] hold_val;
    logic             latch_rise;

    rise_detect u_latch_rise (
        .clk_i    (CLK),
        .rst_ni   (RESET_N),
        .strobe_i (latch),
        .rise_o   (latch_rise)
    );

    // The hold stage is transparent while hold is low.
    always_comb begin
        hold_val = hold ? hold_q : in;
    end

    // Hold stage tracks in, or is cleared or frozen while hold is high.
    always_comb begin
        hold_d = hold_q;
        if (!hold) begin
            hold_d = in;
        end else if (clear) begin
            hold_d = '0;
        end
    end

    // Data priority is clear, then load on the latch rise, then increment, then hold.
    always_comb begin
        data_d   = data_q;
        carry_d  = carry_q;
        loaded_d = latch_rise & ~clear;
        if (clear) begin
            data_d  = '0;
            carry_d = 1'b0;
        end else if (latch_rise) begin
            data_d  = hold_val;
            carry_d = 1'b0;
        end else if (inc) begin
            data_d = data_q + WIDTH'(1);
            if (&data_q) begin
                carry_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hold_q   <= RESET_VAL;
            data_q   <= RESET_VAL;
            carry_q  <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            hold_q   <= hold_d;
            data_q   <= data_d;
            carry_q  <= carry_d;
            loaded_q <= loaded_d;
        end
    end

    assign data_o = data_q;
    assign loaded = loaded_q;
    assign carry  = carry_q;

    // Per-bus output gating; the enables are not registered.
    for (genvar k = 0; k < NOUT; k++) begin : g_bus
        localparam int unsigned Lsb = bus_lsb(k, WIDTH);
`ifdef MULTILATCH_TRISTATE_EN
        assign out[Lsb +: WIDTH] = oe[k] ? data_q : {WIDTH{1'bz}};
`else
        assign out[Lsb +: WIDTH] = oe[k] ? data_q : {WIDTH{1'b0}};
`endif
    end

endmodule

// File: doc/multilatch_n.md
Name: multilatch_n

Overview:
Parametrised successor to the 12-bit clear/hold/latch register. It is fully synchronous to CLK, with a registered hold stage, an edge-detected latch strobe, synchronous clear and an optional increment mode. It drives NOUT independently enabled output buses onto the CPU datapath bus network, for use as AC/MQ/PC/MA-style registers.

Parameters:
WIDTH, 12, data word width in bits (>=2)
NOUT, 2, number of output buses (>=1)
RESET_VAL, 0, value of data and holdreg after reset

Ports:
CLK  input  1  system clock, all state updates on rising edge
RESET_N  input  1  asynchronous active-low reset
in  input  WIDTH  data input
clear  input  1  synchronous clear, level-sensitive
hold  input  1  1 = freeze hold stage; 0 = hold stage tracks in
latch  input  1  load strobe, acted on at its rising edge only
inc  input  1  increment data by 1, level-sensitive, once per cycle
oe  input  NOUT  per-bus output enable; bit k gates bus k
out  output  NOUT*WIDTH  bus k occupies bits [k*WIDTH +: WIDTH]
data_o  output  WIDTH  unconditional copy of data register
loaded  output  1  one-cycle pulse, the cycle after data was loaded from latch
carry  output  1  sticky wrap flag from increment

Behaviour:
- Reset (RESET_N=0, async): data=RESET_VAL, holdreg=RESET_VAL, latch_q=0, loaded=0, carry=0. Outputs update immediately, with no clock needed.
- Hold value, combinational: hold_val = hold ? holdreg : in. This is transparent when hold=0, as before.
- holdreg per edge: if hold=0, holdreg<=in. Else if clear=1, holdreg<=0. Else holdreg is unchanged.
- Latch edge: latch_q<=latch every cycle. latch_rise = latch & ~latch_q.
- A latch held high loads once. Re-arming needs at least one low sample.
- data per edge, in priority order:
  1. clear: data<=0, carry<=0.
  2. latch_rise: data<=hold_val, carry<=0.
  3. inc: data<=data+1, modulo 2^WIDTH. If data was all ones, carry<=1; otherwise carry holds.
  4. Otherwise data holds.
- Latency: a latch rising at edge k makes data valid after edge k. loaded=1 for the cycle after edge k only.
- loaded<=latch_rise & ~clear. It is 0 when clear suppresses the load.
- Simultaneous latch_rise and clear: clear wins. latch_q still updates, so the strobe is consumed.
- Simultaneous latch_rise and inc: the load wins and the increment is dropped.
- Bus k: out[k] = oe[k] ? data : disabled value (see Optional Feature). Enables are combinational, with no register.
- Reset mid-strobe: latch_q=0 after reset. A latch already high when RESET_N deasserts produces a load on the first edge.

Optional Feature:
MULTILATCH_TRISTATE_EN
- Defined: disabled buses drive all-z, for a true tristate shared bus.
- Undefined (default): disabled buses drive all-0, so buses can be wire-ORed in FPGA fabric.
- All other behaviour is identical either way.

Decomposition:
- Shared package pdp8_pkg: constant WORD_W=12, plus localparam conventions for bus slicing.
- One sub-module, rise_detect: latch_q register plus the rise output, with async active-low reset. It is reused by other strobe-driven registers.

Test Plan:
- Reset: RESET_N=0 with RESET_VAL=0 -> data_o=0, carry=0, loaded=0. Any oe bit set -> that bus reads 0.
- Transparent load: hold=0, in=12'o1234, latch pulse 1 cycle -> data_o=12'o1234 after the edge, loaded=1 for exactly one cycle.
- Held load:
  - hold=0 with in=12'o5555 for 1 cycle, then hold=1 with in=12'o7777, then latch -> data_o=12'o5555.
  - latch held high 5 cycles -> only one load and one loaded pulse.
- Increment wrap: load 12'o7776, inc=1 for 2 cycles -> data_o=12'o7777 then 12'o0000, carry=1. A later latch of 12'o0001 -> carry=0.
- Priority:
  - clear, latch_rise and inc together -> data=0, loaded stays 0.
  - latch_rise and inc together with in=12'o0100 -> data=12'o0100.
- Buses: NOUT=3, data=12'o4321, oe=3'b101 -> buses 0 and 2 read 12'o4321; bus 1 reads 0, or z with MULTILATCH_TRISTATE_EN defined.
